// File: rtl/risc_v_muldiv_seq_if.sv
// Start/done handshake and operand/result bus between the core and the
// sequential multiply/divide unit.
interface risc_v_muldiv_seq_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            kill;
    logic            ready;
    logic            done;
    logic [XLEN-1:0] rd;
    logic            fault;

    modport master (
        output start, funct3, rs1, rs2, kill,
        input  ready, done, rd, fault
    );

    modport slave (
        input  start, funct3, rs1, rs2, kill,
        output ready, done, rd, fault
    );
endinterface

// File: rtl/risc_v_muldiv_seq.sv
// Sequential RV32M/RV64M unit: fixed-latency pipelined multiply, radix-2
// restoring divide, RISC-V divide-by-zero/overflow results, kill abort.
//
// state  | meaning
// S_IDLE | ready for a new op (also the done cycle)
// S_MUL  | waiting for the product to leave the multiply pipeline
// S_DIV  | one restoring quotient bit per cycle, MSB first
// S_FIX  | sign correction of quotient/remainder, then done
// S_SPEC | divide by zero or signed overflow, result precomputed at accept
// S_FLT  | divide op with divide support disabled, done with fault
module risc_v_muldiv_seq #(
    parameter int    XLEN           = 32,
    parameter int    MUL_LATENCY    = 2,
    parameter string EXTENSION_MDIV = "TRUE"
) (
    input  logic               i_clk,
    input  logic               i_rst,
    risc_v_muldiv_seq_if.slave io_bus
);

    localparam int              CW      = $clog2(XLEN);
    localparam bit              MDIV_EN = (EXTENSION_MDIV != "FALSE");
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_SPEC,
        S_FLT
    } state_t;

    state_t            r_state;
    logic              r_ready;
    logic              r_done;
    logic              r_fault;
    logic [XLEN-1:0]   r_rd;
    logic [CW-1:0]     r_cnt;
    logic [1:0]        r_f3;
    logic [XLEN-1:0]   r_q;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_dvs;
    logic              r_q_neg;
    logic              r_r_neg;
    logic [2*XLEN-1:0] r_mpipe [MUL_LATENCY];

    logic              w_accept;
    logic              w_is_div;
    logic              w_sgn_div;
    logic              w_a_sx;
    logic              w_b_sx;
    logic [2*XLEN-1:0] w_ma;
    logic [2*XLEN-1:0] w_mb;
    logic [2*XLEN-1:0] w_prod;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic              w_b_zero;
    logic              w_ovf;
    logic [XLEN-1:0]   w_spec_res;
    logic [XLEN:0]     w_rem_sh;
    logic [XLEN:0]     w_sub;
    logic              w_keep;
    logic [XLEN-1:0]   w_mul_res;
    logic [XLEN-1:0]   w_q_fix;
    logic [XLEN-1:0]   w_r_fix;

    assign w_accept  = io_bus.start & r_ready & ~io_bus.kill;
    assign w_is_div  = io_bus.funct3[2];
    assign w_sgn_div = ~io_bus.funct3[0];

    // Operands extended past XLEN; only the low 2*XLEN product bits are ever
    // selected, so the extension stops there without changing those bits.
    assign w_a_sx = (io_bus.funct3 == 3'b001) || (io_bus.funct3 == 3'b010);
    assign w_b_sx = (io_bus.funct3 == 3'b001);
    assign w_ma   = {{XLEN{w_a_sx & io_bus.rs1[XLEN-1]}}, io_bus.rs1};
    assign w_mb   = {{XLEN{w_b_sx & io_bus.rs2[XLEN-1]}}, io_bus.rs2};
    assign w_prod = w_ma * w_mb;

    assign w_a_neg  = w_sgn_div & io_bus.rs1[XLEN-1];
    assign w_b_neg  = w_sgn_div & io_bus.rs2[XLEN-1];
    assign w_abs_a  = w_a_neg ? -io_bus.rs1 : io_bus.rs1;
    assign w_abs_b  = w_b_neg ? -io_bus.rs2 : io_bus.rs2;
    assign w_b_zero = (io_bus.rs2 == '0);
    assign w_ovf    = w_sgn_div && (io_bus.rs1 == MIN_NEG) && (io_bus.rs2 == '1);

    always_comb begin
        w_spec_res = '0;
        if (w_b_zero) begin
            w_spec_res = io_bus.funct3[1] ? io_bus.rs1 : '1;
        end else begin
            w_spec_res = io_bus.funct3[1] ? '0 : io_bus.rs1;
        end
    end

    assign w_rem_sh  = {r_rem, r_q[XLEN-1]};
    assign w_sub     = w_rem_sh - {1'b0, r_dvs};
    assign w_keep    = ~w_sub[XLEN];
    assign w_mul_res = (r_f3 == 2'b00) ? r_mpipe[MUL_LATENCY-1][XLEN-1:0]
                                       : r_mpipe[MUL_LATENCY-1][2*XLEN-1:XLEN];
    assign w_q_fix   = r_q_neg ? -r_q : r_q;
    assign w_r_fix   = r_r_neg ? -r_rem : r_rem;

    // Free-running: stage k holds the product of the operands seen k edges ago.
    always_ff @(posedge i_clk) begin
        r_mpipe[0] <= w_prod;
        for (int i = 1; i < MUL_LATENCY; i++) begin
            r_mpipe[i] <= r_mpipe[i-1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_fault <= 1'b0;
            r_rd    <= '0;
            r_cnt   <= '0;
        end else begin
            r_done  <= 1'b0;
            r_fault <= 1'b0;
            if (r_state != S_IDLE && io_bus.kill) begin
                r_state <= S_IDLE;
                r_ready <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_accept) begin
                            r_ready <= 1'b0;
                            r_f3    <= io_bus.funct3[1:0];
                            if (!w_is_div) begin
                                r_state <= S_MUL;
                                r_cnt   <= CW'(MUL_LATENCY-1);
                            end else if (!MDIV_EN) begin
                                r_state <= S_FLT;
                            end else if (w_b_zero || w_ovf) begin
                                r_state <= S_SPEC;
                                r_q     <= w_spec_res;
                            end else begin
                                r_state <= S_DIV;
                                r_cnt   <= CW'(XLEN-1);
                                r_q     <= w_abs_a;
                                r_rem   <= '0;
                                r_dvs   <= w_abs_b;
                                r_q_neg <= w_a_neg ^ w_b_neg;
                                r_r_neg <= w_a_neg;
                            end
                        end
                    end
                    S_MUL: begin
                        if (r_cnt == '0) begin
                            r_rd    <= w_mul_res;
                            r_done  <= 1'b1;
                            r_ready <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    S_DIV: begin
                        // r_q doubles as the dividend shifter and quotient collector.
                        r_rem <= w_keep ? w_sub[XLEN-1:0] : w_rem_sh[XLEN-1:0];
                        r_q   <= {r_q[XLEN-2:0], w_keep};
                        if (r_cnt == '0) begin
                            r_state <= S_FIX;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    S_FIX: begin
                        r_rd    <= r_f3[1] ? w_r_fix : w_q_fix;
                        r_done  <= 1'b1;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                    S_SPEC: begin
                        r_rd    <= r_q;
                        r_done  <= 1'b1;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                    S_FLT: begin
                        r_rd    <= '0;
                        r_fault <= 1'b1;
                        r_done  <= 1'b1;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign io_bus.ready = r_ready;
    assign io_bus.done  = r_done;
    assign io_bus.rd    = r_rd;
    assign io_bus.fault = r_fault;

endmodule

// File: tb/tb_risc_v_muldiv_seq.sv
// Directed bench for risc_v_muldiv_seq (XLEN=32, MUL_LATENCY=2); a second
// instance with divide support disabled checks the fault path.
module tb_risc_v_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        t_start;
    logic        t_kill;
    logic [2:0]  t_f3;
    logic [31:0] t_rs1;
    logic [31:0] t_rs2;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    risc_v_muldiv_seq_if #(.XLEN(32)) if_a ();
    risc_v_muldiv_seq_if #(.XLEN(32)) if_b ();

    assign if_a.start  = t_start;
    assign if_a.kill   = t_kill;
    assign if_a.funct3 = t_f3;
    assign if_a.rs1    = t_rs1;
    assign if_a.rs2    = t_rs2;
    assign if_b.start  = t_start;
    assign if_b.kill   = t_kill;
    assign if_b.funct3 = t_f3;
    assign if_b.rs1    = t_rs1;
    assign if_b.rs2    = t_rs2;

    risc_v_muldiv_seq #(.XLEN(32), .MUL_LATENCY(2), .EXTENSION_MDIV("TRUE")) u_dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (if_a.slave)
    );

    risc_v_muldiv_seq #(.XLEN(32), .MUL_LATENCY(2), .EXTENSION_MDIV("FALSE")) u_flt (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (if_b.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic s_done(input bit b);
        return b ? if_b.done : if_a.done;
    endfunction

    function automatic logic s_ready(input bit b);
        return b ? if_b.ready : if_a.ready;
    endfunction

    function automatic logic s_fault(input bit b);
        return b ? if_b.fault : if_a.fault;
    endfunction

    function automatic logic [31:0] s_rd(input bit b);
        return b ? if_b.rd : if_a.rd;
    endfunction

    // Issue one op in the current cycle, scramble the inputs after accept,
    // then wait (bounded) for done and check latency, busy time and result.
    task automatic do_op(input bit use_b, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_rd,
                         input logic exp_flt, input int lat, input string tag);
        int n;
        int low;
        chk({tag, "_ready_in"}, {31'b0, s_ready(use_b)}, 32'd1);
        t_start = 1'b1;
        t_f3    = f;
        t_rs1   = a;
        t_rs2   = b;
        tick();
        t_start = 1'b0;
        t_f3    = ~f;
        t_rs1   = $urandom;
        t_rs2   = $urandom;
        n   = 0;
        low = 0;
        while (!s_done(use_b) && n < 60) begin
            if (!s_ready(use_b)) low++;
            tick();
            n++;
        end
        chk({tag, "_done"},  {31'b0, s_done(use_b)}, 32'd1);
        chk({tag, "_lat"},   32'(n), 32'(lat));
        chk({tag, "_busy"},  32'(low), 32'(lat));
        chk({tag, "_rd"},    s_rd(use_b), exp_rd);
        chk({tag, "_fault"}, {31'b0, s_fault(use_b)}, {31'b0, exp_flt});
        chk({tag, "_ready"}, {31'b0, s_ready(use_b)}, 32'd1);
    endtask

    logic [31:0] bb_a   [4];
    logic [31:0] bb_b   [4];
    logic [31:0] bb_exp [4];

    initial begin
        int n;
        int cnt;
        rst     = 1'b1;
        t_start = 1'b0;
        t_kill  = 1'b0;
        t_f3    = 3'b000;
        t_rs1   = '0;
        t_rs2   = '0;
        tick();
        tick();
        chk("rst_ready", {31'b0, if_a.ready}, 32'd1);
        chk("rst_done",  {31'b0, if_a.done},  32'd0);
        chk("rst_fault", {31'b0, if_a.fault}, 32'd0);
        chk("rst_rd",    if_a.rd, 32'd0);
        chk("rst_rd_b",  if_b.rd, 32'd0);
        rst = 1'b0;
        tick();

        // Multiply
        do_op(0, 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, 2, "mul_neg");
        tick();
        chk("done_pulse", {31'b0, if_a.done}, 32'd0);
        do_op(0, 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, 2, "mulh_min");
        do_op(0, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 2, "mulhsu");
        do_op(0, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 2, "mulhu");
        do_op(0, 3'b001, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 0, 2, "mulh_mix");

        // Divide / remainder
        do_op(0, 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, 33, "div_neg");
        do_op(0, 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, 33, "rem_neg");
        do_op(0, 3'b101, 32'd100, 32'd7, 32'd14, 0, 33, "divu");
        do_op(0, 3'b111, 32'd100, 32'd7, 32'd2,  0, 33, "remu");
        do_op(0, 3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 0, 33, "div_negdvs");
        do_op(0, 3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 0, 33, "rem_negdvs");
        do_op(0, 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, 33, "divu_big");
        do_op(0, 3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 33, "remu_big");

        // Divide by zero and signed overflow
        do_op(0, 3'b101, 32'd100, 32'd0, 32'hFFFF_FFFF, 0, 1, "divu_z");
        do_op(0, 3'b111, 32'd100, 32'd0, 32'd100, 0, 1, "remu_z");
        do_op(0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1, "div_ovf");
        do_op(0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0, 1, "rem_ovf");
        do_op(0, 3'b100, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 0, 1, "div_z");
        do_op(0, 3'b110, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 0, 1, "rem_z");

        // kill ten cycles into a divide
        tick();
        t_start = 1'b1;
        t_f3    = 3'b100;
        t_rs1   = 32'd1000;
        t_rs2   = 32'd3;
        tick();
        t_start = 1'b0;
        repeat (9) tick();
        chk("kill_busy", {31'b0, if_a.ready}, 32'd0);
        t_kill = 1'b1;
        tick();
        t_kill = 1'b0;
        chk("kill_ready", {31'b0, if_a.ready}, 32'd1);
        chk("kill_done",  {31'b0, if_a.done},  32'd0);
        chk("kill_rd",    if_a.rd, 32'hFFFF_FFFB);
        cnt = 0;
        repeat (40) begin
            tick();
            if (if_a.done) cnt++;
        end
        chk("kill_no_late_done", 32'(cnt), 32'd0);
        do_op(0, 3'b011, 32'd3, 32'd5, 32'd0,  0, 2, "mulhu_small");
        do_op(0, 3'b000, 32'd3, 32'd5, 32'd15, 0, 2, "mul_small");

        // kill in the done cycle changes nothing
        t_kill = 1'b1;
        tick();
        t_kill = 1'b0;
        chk("kill_done_cyc_rd",    if_a.rd, 32'd15);
        chk("kill_done_cyc_ready", {31'b0, if_a.ready}, 32'd1);

        // kill together with start blocks the accept
        t_start = 1'b1;
        t_kill  = 1'b1;
        t_f3    = 3'b000;
        t_rs1   = 32'd2;
        t_rs2   = 32'd2;
        tick();
        t_start = 1'b0;
        t_kill  = 1'b0;
        chk("kill_start_ready", {31'b0, if_a.ready}, 32'd1);
        cnt = 0;
        repeat (4) begin
            tick();
            if (if_a.done) cnt++;
        end
        chk("kill_start_no_done", 32'(cnt), 32'd0);
        chk("kill_start_rd", if_a.rd, 32'd15);

        // reset in the middle of a divide
        t_start = 1'b1;
        t_f3    = 3'b100;
        t_rs1   = 32'd1000;
        t_rs2   = 32'd3;
        tick();
        t_start = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_abort_rd",    if_a.rd, 32'd0);
        chk("rst_abort_ready", {31'b0, if_a.ready}, 32'd1);
        chk("rst_abort_done",  {31'b0, if_a.done},  32'd0);
        cnt = 0;
        repeat (40) begin
            tick();
            if (if_a.done) cnt++;
        end
        chk("rst_abort_no_done", 32'(cnt), 32'd0);

        // start held high over four queued multiplies
        bb_a[0] = 32'd2;         bb_b[0] = 32'd3;         bb_exp[0] = 32'd6;
        bb_a[1] = 32'h0000_FFFF; bb_b[1] = 32'h0001_0001; bb_exp[1] = 32'hFFFF_FFFF;
        bb_a[2] = 32'h8000_0000; bb_b[2] = 32'd2;         bb_exp[2] = 32'd0;
        bb_a[3] = 32'hFFFF_FFFF; bb_b[3] = 32'hFFFF_FFFF; bb_exp[3] = 32'd1;
        t_start = 1'b1;
        t_f3    = 3'b000;
        t_rs1   = bb_a[0];
        t_rs2   = bb_b[0];
        tick();
        for (int k = 0; k < 4; k++) begin
            if (k < 3) begin
                t_rs1 = bb_a[k+1];
                t_rs2 = bb_b[k+1];
            end else begin
                t_start = 1'b0;
            end
            n = 0;
            while (!if_a.done && n < 10) begin
                tick();
                n++;
            end
            chk($sformatf("b2b%0d_lat", k), 32'(n), 32'd2);
            chk($sformatf("b2b%0d_rd", k), if_a.rd, bb_exp[k]);
            tick();
            if (k < 3) chk($sformatf("b2b%0d_next_acc", k), {31'b0, if_a.ready}, 32'd0);
        end

        // divide support disabled
        tick();
        do_op(1, 3'b000, 32'd6, 32'd7, 32'd42, 0, 2, "flt_mul");
        do_op(1, 3'b100, 32'd100, 32'd7, 32'd0, 1, 1, "flt_div");
        do_op(1, 3'b111, 32'd100, 32'd0, 32'd0, 1, 1, "flt_remu");

        n = 0;
        while (!if_a.ready && n < 100) begin
            tick();
            n++;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
